// File: rtl/spi_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module   : spi_tx_arbiter
// Brief    : Two-requester arbiter feeding one SPI master; IDLE/LOAD/WAIT FSM
//            with a WAIT-state timeout. Define SPI_ARB_FIXED_PRIO_EN for fixed
//            priority (requester 0 wins ties) instead of round-robin.
// Revision : 1.0 - initial release
// =============================================================================
module spi_tx_arbiter #(
   parameter int WIDTH       = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic             spi_done,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic [WIDTH-1:0] tx_data,
   output logic             tx_start,
   output logic             busy,
   output logic             timeout_err
);

   localparam int               CNT_W   = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_tx_start;
   logic             r_tout;
   logic             r_sel;
   logic [WIDTH-1:0] r_tx_data;
   logic             w_gnt0_nxt;
   logic             w_gnt1_nxt;
   logic             w_tx_start_nxt;
   logic             w_tout_nxt;
   logic             w_sel_nxt;
   logic [WIDTH-1:0] w_tx_data_nxt;
   logic             w_any_req;
   logic             w_winner;

   assign w_any_req = req0 | req1;

`ifdef SPI_ARB_FIXED_PRIO_EN
   assign w_winner = ~req0;
`else
   // Last-served pointer; resets to 1 so requester 0 wins the first tie.
   logic r_last;

   assign w_winner = (req0 & req1) ? ~r_last : req1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last <= 1'b1;
      end else if ((r_state == ST_IDLE) && w_any_req) begin
         r_last <= w_winner;
      end
   end
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_gnt0_nxt     = 1'b0;
      w_gnt1_nxt     = 1'b0;
      w_tx_start_nxt = 1'b0;
      w_tout_nxt     = 1'b0;
      w_sel_nxt      = r_sel;
      w_tx_data_nxt  = r_tx_data;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_sel_nxt     = w_winner;
               w_tx_data_nxt = w_winner ? data1 : data0;
               w_gnt0_nxt    = ~w_winner;
               w_gnt1_nxt    = w_winner;
               w_state_nxt   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_tx_start_nxt = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = ST_WAIT;
         end
         ST_WAIT: begin
            // Completion takes precedence over a timeout on the same edge.
            if (spi_done) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == CNT_MAX) begin
               w_tout_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_tx_start <= 1'b0;
         r_tout     <= 1'b0;
         r_sel      <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_gnt0     <= w_gnt0_nxt;
         r_gnt1     <= w_gnt1_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_tout     <= w_tout_nxt;
         r_sel      <= w_sel_nxt;
         r_tx_data  <= w_tx_data_nxt;
      end
   end

   assign gnt0        = r_gnt0;
   assign gnt1        = r_gnt1;
   assign sel         = r_sel;
   assign tx_data     = r_tx_data;
   assign tx_start    = r_tx_start;
   assign timeout_err = r_tout;
   assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module   : tb_spi_tx_arbiter
// Brief    : Scoreboard bench for spi_tx_arbiter (TIMEOUT_CYC = 8); expected
//            grant/start/timeout events are queued with their cycle numbers.
// Revision : 1.0 - initial release
// =============================================================================
module tb_spi_tx_arbiter;

   localparam logic [1:0] K_GNT   = 2'd0;
   localparam logic [1:0] K_START = 2'd1;
   localparam logic [1:0] K_TOUT  = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic        id;
      logic [31:0] data;
      logic [31:0] cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [31:0] data0 = '0;
   logic [31:0] data1 = '0;
   logic        spi_done = 1'b0;
   logic        gnt0;
   logic        gnt1;
   logic        sel;
   logic [31:0] tx_data;
   logic        tx_start;
   logic        busy;
   logic        timeout_err;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   ev_t  sb[$];
   logic exp_rr [4];

   spi_tx_arbiter #(
      .WIDTH       (32),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req0        (req0),
      .req1        (req1),
      .data0       (data0),
      .data1       (data1),
      .spi_done    (spi_done),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .sel         (sel),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input logic [1:0] kind, input logic id, input logic [31:0] data,
                            input int at);
      ev_t e;
      e.kind = kind;
      e.id   = id;
      e.data = data;
      e.cyc  = 32'(at);
      sb.push_back(e);
   endtask

   // Monitor: every output pulse must match the head of the scoreboard.
   always @(negedge clk) begin : mon
      ev_t        e;
      logic [1:0] k;
      if (gnt0 || gnt1 || tx_start || timeout_err) begin
         k = (gnt0 || gnt1) ? K_GNT : (tx_start ? K_START : K_TOUT);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", k, cyc);
         end else begin
            e = sb.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            check("event_cycle", 32'(cyc), e.cyc);
            if (e.kind == K_GNT) begin
               check("gnt_onehot", 32'({gnt0, gnt1}), e.id ? 32'h1 : 32'h2);
               check("sel", 32'(sel), 32'(e.id));
               check("tx_data", tx_data, e.data);
            end
         end
      end
   end

   // Called in an IDLE cycle (#1 after an edge); returns in the tx_start cycle.
   task automatic start_xfer(input logic r0, input logic r1, input logic exp_id,
                             input logic [31:0] exp_data, input logic hold,
                             input logic done_in_load);
      int t0;
      t0   = cyc;
      req0 = r0;
      req1 = r1;
      expect_ev(K_GNT, exp_id, exp_data, t0 + 1);
      expect_ev(K_START, 1'b0, 32'h0, t0 + 2);
      @(posedge clk); #1;
      if (!hold) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
      spi_done = done_in_load;
      @(posedge clk); #1;
      spi_done = 1'b0;
      check("busy_in_wait", 32'(busy), 32'h1);
   endtask

   // spi_done is driven d cycles after the tx_start cycle.
   task automatic finish_done(input int d);
      repeat (d) begin
         @(posedge clk); #1;
      end
      spi_done = 1'b1;
      @(posedge clk); #1;
      spi_done = 1'b0;
      check("busy_after_done", 32'(busy), 32'h0);
   endtask

   task automatic finish_timeout(input logic [31:0] exp_data);
      expect_ev(K_TOUT, 1'b0, 32'h0, cyc + 8);
      repeat (7) begin
         @(posedge clk); #1;
      end
      check("busy_before_timeout", 32'(busy), 32'h1);
      @(posedge clk); #1;
      check("busy_after_timeout", 32'(busy), 32'h0);
      check("tx_data_held", tx_data, exp_data);
   endtask

   initial begin
`ifdef SPI_ARB_FIXED_PRIO_EN
      exp_rr = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset_flags", 32'({gnt0, gnt1, tx_start, timeout_err, busy, sel}), 32'h0);
      check("reset_tx_data", tx_data, 32'h0);
      reset = 1'b1;

      // Both requesters held high: four transfers.
      data0 = 32'hA5A5_0001;
      data1 = 32'h0000_BEEF;
      for (int i = 0; i < 4; i++) begin
         start_xfer(1'b1, 1'b1, exp_rr[i], exp_rr[i] ? data1 : data0, (i < 3), 1'b0);
         finish_done(i);
      end

      // Single requester wins regardless of the pointer.
      start_xfer(1'b0, 1'b1, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
      finish_done(0);

      // Basic transfer, done 5 cycles after tx_start.
      start_xfer(1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0);
      finish_done(5);

      // Timeout with no spi_done.
      data0 = 32'h1111_2222;
      start_xfer(1'b1, 1'b0, 1'b0, 32'h1111_2222, 1'b0, 1'b0);
      finish_timeout(32'h1111_2222);

      // spi_done on the timeout edge: no timeout_err.
      data1 = 32'h3333_4444;
      start_xfer(1'b0, 1'b1, 1'b1, 32'h3333_4444, 1'b0, 1'b0);
      finish_done(7);

      // spi_done in IDLE and in LOAD is ignored.
      spi_done = 1'b1;
      @(posedge clk); #1;
      spi_done = 1'b0;
      check("busy_after_idle_done", 32'(busy), 32'h0);
      start_xfer(1'b1, 1'b0, 1'b0, 32'h1111_2222, 1'b0, 1'b1);
      finish_done(2);

      // Reset during WAIT, then an immediate grant once reset is released.
      start_xfer(1'b0, 1'b1, 1'b1, 32'h3333_4444, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("wait_reset_flags", 32'({gnt0, gnt1, tx_start, timeout_err, busy, sel}), 32'h0);
      check("wait_reset_tx_data", tx_data, 32'h0);
      reset = 1'b1;
      data1 = 32'hCAFE_0002;
      start_xfer(1'b0, 1'b1, 1'b1, 32'hCAFE_0002, 1'b0, 1'b0);
      finish_done(1);

      repeat (12) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish by 100000ns");
      $fatal(1);
   end

endmodule
`default_nettype wire
